// File: rtl/token_table_loader.sv
// Boot/reload sequencer for the decompressor token table; table writes issue 1 cycle after each accepted word.
// wr_ready is high only while loading; lookups are granted only once the full table has been written.
module token_table_loader #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 102,
    parameter int PCADD = 4,
    parameter int BASE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic             load_abort,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             tbl_wme,
    output logic [WIDTH-1:0] tbl_addr,
    output logic [WIDTH-1:0] tbl_wdata,
    input  logic             dec_req,
    output logic             dec_grant,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, READY} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            wr_en;
    logic [WIDTH-1:0] addr_calc;

    assign addr_calc = WIDTH'(BASE) + WIDTH'(count) * WIDTH'(PCADD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            tbl_wme   <= 1'b0;
            tbl_addr  <= '0;
            tbl_wdata <= '0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            tbl_wme <= wr_en;
            if (wr_en) begin
                tbl_addr  <= addr_calc;
                tbl_wdata <= wr_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wr_ready  = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        dec_grant = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                end
            end
            LOAD: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
                // An abort drops the word accepted in the same cycle rather than writing it.
                if (load_abort) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else if (wr_valid) begin
                    wr_en = 1'b1;
                    if (count == LAST) begin
                        state_nxt = COMMIT;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            COMMIT: begin
                busy      = 1'b1;
                state_nxt = READY;
            end
            READY: begin
                done      = 1'b1;
                dec_grant = dec_req;
                if (load_start) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_token_table_loader.sv
// Directed bench for token_table_loader: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_token_table_loader;

    localparam int WIDTH = 32;
    localparam int SIZE  = 102;
    localparam int PCADD = 4;
    localparam int BASE  = 0;

    localparam int M_IDLE = 0, M_LOAD = 1, M_COMMIT = 2, M_READY = 3;

    logic             clk = 1'b0;
    logic             reset, load_start, load_abort, wr_valid, dec_req;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready, tbl_wme, dec_grant, busy, done;
    logic [WIDTH-1:0] tbl_addr, tbl_wdata;

    token_table_loader #(.WIDTH(WIDTH), .SIZE(SIZE), .PCADD(PCADD), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_abort(load_abort),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .tbl_wme(tbl_wme), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .dec_req(dec_req), .dec_grant(dec_grant), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which phase the load is in, how many words accepted, and the last write.
    int          m_mode = M_IDLE;
    int          m_k    = 0;
    logic        m_wme  = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = M_IDLE; m_k = 0; m_wme = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            m_wme = (m_mode == M_LOAD) && wr_valid && !load_abort;
            if (m_wme) begin
                m_addr = BASE + m_k * PCADD;
                m_data = wr_data;
            end
            if (m_mode == M_IDLE) begin
                if (load_start) begin m_mode = M_LOAD; m_k = 0; end
            end else if (m_mode == M_LOAD) begin
                if (load_abort) begin
                    m_mode = M_IDLE; m_k = 0;
                end else if (wr_valid) begin
                    m_k = m_k + 1;
                    if (m_k == SIZE) begin m_mode = M_COMMIT; m_k = 0; end
                end
            end else if (m_mode == M_COMMIT) begin
                m_mode = M_READY;
            end else if (load_start) begin
                m_mode = M_LOAD; m_k = 0;
            end
        end
    end

    // Per-cycle comparison and DUT activity counters used by the literal checkpoints.
    logic        chk_en = 1'b0;
    int          wme_cnt = 0, grant_cnt = 0;
    logic [31:0] first_addr = '0, last_addr = '0, last_data = '0;
    logic        seen_first = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_ready",  32'(wr_ready),  32'(m_mode == M_LOAD));
            chk("busy",      32'(busy),      32'(m_mode == M_LOAD || m_mode == M_COMMIT));
            chk("done",      32'(done),      32'(m_mode == M_READY));
            chk("dec_grant", 32'(dec_grant), 32'(dec_req && m_mode == M_READY));
            chk("tbl_wme",   32'(tbl_wme),   32'(m_wme));
            chk("tbl_addr",  tbl_addr,  m_addr);
            chk("tbl_wdata", tbl_wdata, m_data);
            chk("wme_vs_grant", 32'(tbl_wme & dec_grant), 32'd0);
        end
        if (tbl_wme === 1'b1) begin
            wme_cnt++;
            last_addr = tbl_addr;
            last_data = tbl_wdata;
            if (!seen_first) begin first_addr = tbl_addr; seen_first = 1'b1; end
        end
        if (dec_grant === 1'b1) grant_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        wme_cnt = 0; grant_cnt = 0; seen_first = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; load_abort = 1'b0;
        wr_valid = 1'b0; wr_data = '0; dec_req = 1'b0;
        step();
        chk_en = 1'b1;
        wr_valid = 1'b1;
        step(); step();
        settle();
        chk("rst_wme",   32'(tbl_wme), 32'd0);
        chk("rst_addr",  tbl_addr, 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        reset = 1'b0;
        step(); step();
        settle();
        chk("idle_ignores_valid", 32'(tbl_wme), 32'd0);
        wr_valid = 1'b0;

        // Back-to-back load with a lookup request held throughout.
        dec_req = 1'b1;
        load_start = 1'b1; step(); load_start = 1'b0;
        clr();
        for (int i = 0; i < SIZE; i++) begin
            wr_valid = 1'b1; wr_data = i; step();
        end
        wr_valid = 1'b0;
        step();
        settle();
        chk("b2b_wme_cnt",    wme_cnt, 32'd102);
        chk("b2b_first_addr", first_addr, 32'd0);
        chk("b2b_last_addr",  last_addr, 32'd404);
        chk("b2b_last_data",  last_data, 32'd101);
        chk("b2b_done",       32'(done), 32'd1);
        chk("b2b_grant_cnt",  grant_cnt, 32'd1);

        // Reload from READY with a 1-of-3 gapped stream; start/abort pokes in LOAD/COMMIT are ignored.
        load_start = 1'b1; step(); load_start = 1'b0;
        clr();
        for (int c = 0; c < 306; c++) begin
            wr_valid   = (c % 3 == 0);
            wr_data    = 1000 + c / 3;
            load_start = (c == 150 || c == 304);
            load_abort = (c == 304);
            step();
        end
        wr_valid = 1'b0; load_start = 1'b0; load_abort = 1'b0;
        settle();
        chk("gap_wme_cnt",    wme_cnt, 32'd102);
        chk("gap_first_addr", first_addr, 32'd0);
        chk("gap_last_addr",  last_addr, 32'd404);
        chk("gap_last_data",  last_data, 32'd1101);
        chk("gap_done",       32'(done), 32'd1);
        chk("gap_grant_cnt",  grant_cnt, 32'd2);

        // Abort on the 51st word.
        load_start = 1'b1; step(); load_start = 1'b0;
        clr();
        for (int i = 0; i < 50; i++) begin
            wr_valid = 1'b1; wr_data = 200 + i; step();
        end
        wr_data = 999; load_abort = 1'b1; step(); load_abort = 1'b0;
        settle();
        chk("abt_wme_cnt",   wme_cnt, 32'd50);
        chk("abt_last_addr", last_addr, 32'd196);
        chk("abt_last_data", last_data, 32'd249);
        clr();
        repeat (5) step();
        wr_valid = 1'b0;
        settle();
        chk("abt_no_wme", wme_cnt, 32'd0);
        chk("abt_done",   32'(done), 32'd0);
        chk("abt_grant",  grant_cnt, 32'd0);
        load_start = 1'b1; step(); load_start = 1'b0;
        clr();
        wr_valid = 1'b1; wr_data = 77; step(); wr_valid = 1'b0;
        settle();
        chk("restart_addr", first_addr, 32'd0);
        chk("restart_data", last_data, 32'd77);
        load_abort = 1'b1; step(); load_abort = 1'b0;

        // Reset on the 11th word.
        load_start = 1'b1; step(); load_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_data = 300 + i; step();
        end
        wr_data = 555; reset = 1'b1; step(); reset = 1'b0;
        clr();
        repeat (5) step();
        wr_valid = 1'b0;
        settle();
        chk("rst10_wme_cnt", wme_cnt, 32'd0);
        chk("rst10_addr",    tbl_addr, 32'd0);
        chk("rst10_data",    tbl_wdata, 32'd0);
        chk("rst10_busy",    32'(busy), 32'd0);
        chk("rst10_done",    32'(done), 32'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
